// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The master drives hazard requests and consumes stage controls; the slave
// is the hazard controller itself.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             STALL;
  logic             BRANCH_TAKEN;
  logic             MEM_REQ;
  logic             MEM_READY;
  logic             PC_EN;
  logic             IFID_EN;
  logic             IFID_FLUSH;
  logic             IDEX_EN;
  logic             IDEX_FLUSH;
  logic             EXMEM_EN;
  logic             MEMWB_BUBBLE;
  logic             TIMEOUT;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;

  modport master (
    output STALL, BRANCH_TAKEN, MEM_REQ, MEM_READY,
    input  PC_EN, IFID_EN, IFID_FLUSH, IDEX_EN, IDEX_FLUSH, EXMEM_EN,
           MEMWB_BUBBLE, TIMEOUT, STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  STALL, BRANCH_TAKEN, MEM_REQ, MEM_READY,
    output PC_EN, IFID_EN, IFID_FLUSH, IDEX_EN, IDEX_FLUSH, EXMEM_EN,
           MEMWB_BUBBLE, TIMEOUT, STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage RV32I pipeline. Arbitrates memory wait >
// control-flow flush > load-use stall, drives per-stage enable/flush/bubble
// controls combinationally, and keeps saturating event counters plus a
// sticky memory-wait timeout flag.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int WAIT_MAX     = 64,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int WCNT_W = $clog2(WAIT_MAX) + 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX     = WCNT_W'(WAIT_MAX);
  localparam logic [WCNT_W-1:0] WCNT_ONE     = WCNT_W'(1);
  localparam logic [3:0]        FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  state_t            ret_reg, ret_next;
  logic [3:0]        fcnt_reg, fcnt_next;
  logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
  logic              timeout_reg, timeout_next;

  // Counter 0 counts load-use bubbles, counter 1 counts redirects.
  logic [CNT_W-1:0]  cnt_reg [2];
  logic [1:0]        cnt_inc;

  logic   freeze;
  state_t eff_state;
  logic   do_branch;
  logic   do_stall;
  logic   do_flush;

  // Decode which hazard wins this cycle. A released WAIT behaves exactly as
  // the state it interrupted, so the instructions held during the wait are
  // re-evaluated in the same cycle the memory lets go.
  always_comb begin
    freeze    = bus.MEM_REQ & ~bus.MEM_READY;
    eff_state = (state_reg == S_WAIT) ? ret_reg : state_reg;
    do_branch = ~freeze & (eff_state == S_RUN) & bus.BRANCH_TAKEN;
    do_stall  = ~freeze & (eff_state == S_RUN) & ~bus.BRANCH_TAKEN & bus.STALL;
    do_flush  = ~freeze & (eff_state == S_FLUSH);
  end

  // State and supporting registers; reset abandons any wait or flush.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg   <= S_RUN;
      ret_reg     <= S_RUN;
      fcnt_reg    <= 4'd0;
      wcnt_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ret_reg     <= ret_next;
      fcnt_reg    <= fcnt_next;
      wcnt_reg    <= wcnt_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next-state logic for the RUN/FLUSH/WAIT machine and its helpers.
  always_comb begin
    state_next   = state_reg;
    ret_next     = ret_reg;
    fcnt_next    = fcnt_reg;
    wcnt_next    = wcnt_reg;
    timeout_next = timeout_reg;
    cnt_inc      = 2'b00;
    if (freeze) begin
      if (state_reg != S_WAIT) begin
        ret_next   = state_reg;
        wcnt_next  = WCNT_ONE;
        state_next = S_WAIT;
      end else if (wcnt_reg != WCNT_MAX) begin
        wcnt_next = wcnt_reg + WCNT_ONE;
      end
      if (wcnt_next == WCNT_MAX) begin
        timeout_next = 1'b1;
      end
    end else begin
      wcnt_next  = '0;
      state_next = eff_state;
      if (do_branch) begin
        cnt_inc[1] = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          fcnt_next  = FLUSH_RELOAD;
          state_next = S_FLUSH;
        end
      end else if (do_stall) begin
        cnt_inc[0] = 1'b1;
      end else if (do_flush) begin
        if (bus.BRANCH_TAKEN) begin
          cnt_inc[1] = 1'b1;
          fcnt_next  = FLUSH_RELOAD;
          state_next = S_FLUSH;
        end else begin
          fcnt_next  = fcnt_reg - 4'd1;
          state_next = (fcnt_reg <= 4'd1) ? S_RUN : S_FLUSH;
        end
      end
    end
  end

  // Saturating event counters; they stop at all-ones rather than wrap.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    always_ff @(posedge CLK) begin
      if (!RESET_N) begin
        cnt_reg[gi] <= '0;
      end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  end

  // Stage controls: reset squashes everything, freeze holds the front of the
  // pipe while draining bubbles into MEM/WB, flush squashes IF/ID and ID/EX,
  // stall holds PC and IF/ID while injecting an ID/EX bubble.
  always_comb begin
    bus.PC_EN        = 1'b1;
    bus.IFID_EN      = 1'b1;
    bus.IFID_FLUSH   = 1'b0;
    bus.IDEX_EN      = 1'b1;
    bus.IDEX_FLUSH   = 1'b0;
    bus.EXMEM_EN     = 1'b1;
    bus.MEMWB_BUBBLE = 1'b0;
    if (!RESET_N) begin
      bus.PC_EN        = 1'b0;
      bus.IFID_EN      = 1'b0;
      bus.IFID_FLUSH   = 1'b1;
      bus.IDEX_EN      = 1'b0;
      bus.IDEX_FLUSH   = 1'b1;
      bus.EXMEM_EN     = 1'b0;
      bus.MEMWB_BUBBLE = 1'b1;
    end else if (freeze) begin
      bus.PC_EN        = 1'b0;
      bus.IFID_EN      = 1'b0;
      bus.IDEX_EN      = 1'b0;
      bus.EXMEM_EN     = 1'b0;
      bus.MEMWB_BUBBLE = 1'b1;
    end else if (do_branch || do_flush) begin
      bus.IFID_FLUSH = 1'b1;
      bus.IDEX_FLUSH = 1'b1;
    end else if (do_stall) begin
      bus.PC_EN      = 1'b0;
      bus.IFID_EN    = 1'b0;
      bus.IDEX_FLUSH = 1'b1;
    end
  end

  // Status outputs.
  always_comb begin
    bus.TIMEOUT   = timeout_reg;
    bus.STALL_CNT = cnt_reg[0];
    bus.FLUSH_CNT = cnt_reg[1];
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instance A uses default parameters,
// instance B uses FLUSH_CYCLES=3, WAIT_MAX=4, CNT_W=2.
module tb_pipe_hazard_ctrl;

  logic CLK;
  logic RESET_N;
  int   vectors;
  int   miscompares;

  pipe_hazard_ctrl_if #(.CNT_W(16)) if_a ();
  pipe_hazard_ctrl_if #(.CNT_W(2))  if_b ();

  pipe_hazard_ctrl dut_a (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (if_a)
  );

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES (3),
    .WAIT_MAX     (4),
    .CNT_W        (2)
  ) dut_b (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (if_b)
  );

  // Control vector order: PC_EN, IFID_EN, IFID_FLUSH, IDEX_EN, IDEX_FLUSH,
  // EXMEM_EN, MEMWB_BUBBLE.
  localparam logic [6:0] C_RESET  = 7'b0010101;
  localparam logic [6:0] C_IDLE   = 7'b1101010;
  localparam logic [6:0] C_STALL  = 7'b0001110;
  localparam logic [6:0] C_FLUSH  = 7'b1111110;
  localparam logic [6:0] C_FREEZE = 7'b0000001;

  logic [6:0] ctl_a;
  logic [6:0] ctl_b;
  assign ctl_a = {if_a.PC_EN, if_a.IFID_EN, if_a.IFID_FLUSH, if_a.IDEX_EN,
                  if_a.IDEX_FLUSH, if_a.EXMEM_EN, if_a.MEMWB_BUBBLE};
  assign ctl_b = {if_b.PC_EN, if_b.IFID_EN, if_b.IFID_FLUSH, if_b.IDEX_EN,
                  if_b.IDEX_FLUSH, if_b.EXMEM_EN, if_b.MEMWB_BUBBLE};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RESET_N = 1'b0;
    if_a.STALL = 1'b0; if_a.BRANCH_TAKEN = 1'b0; if_a.MEM_REQ = 1'b0; if_a.MEM_READY = 1'b0;
    if_b.STALL = 1'b0; if_b.BRANCH_TAKEN = 1'b0; if_b.MEM_REQ = 1'b0; if_b.MEM_READY = 1'b0;

    // Reset held for three cycles.
    #2;
    chk("rst_ctl_a", 32'(ctl_a), 32'(C_RESET));
    chk("rst_ctl_b", 32'(ctl_b), 32'(C_RESET));
    repeat (3) tick();
    chk("rst_ctl_a_held", 32'(ctl_a), 32'(C_RESET));
    RESET_N = 1'b1;
    #1;
    chk("post_rst_ctl_a", 32'(ctl_a), 32'(C_IDLE));
    chk("post_rst_ctl_b", 32'(ctl_b), 32'(C_IDLE));
    chk("post_rst_scnt_a", 32'(if_a.STALL_CNT), 0);
    chk("post_rst_fcnt_a", 32'(if_a.FLUSH_CNT), 0);
    chk("post_rst_tmo_a", 32'(if_a.TIMEOUT), 0);
    chk("post_rst_tmo_b", 32'(if_b.TIMEOUT), 0);
    tick();

    // A: single load-use stall.
    if_a.STALL = 1'b1; #1;
    chk("lu_ctl", 32'(ctl_a), 32'(C_STALL));
    tick();
    if_a.STALL = 1'b0; #1;
    chk("lu_after_ctl", 32'(ctl_a), 32'(C_IDLE));
    chk("lu_scnt", 32'(if_a.STALL_CNT), 1);
    tick();

    // A: stall held two cycles gives two bubbles.
    if_a.STALL = 1'b1; #1;
    chk("lu2_ctl0", 32'(ctl_a), 32'(C_STALL));
    tick(); #1;
    chk("lu2_ctl1", 32'(ctl_a), 32'(C_STALL));
    tick();
    if_a.STALL = 1'b0; #1;
    chk("lu2_scnt", 32'(if_a.STALL_CNT), 3);
    tick();

    // A: branch beats stall.
    if_a.STALL = 1'b1; if_a.BRANCH_TAKEN = 1'b1; #1;
    chk("br_stall_ctl", 32'(ctl_a), 32'(C_FLUSH));
    tick();
    if_a.STALL = 1'b0; if_a.BRANCH_TAKEN = 1'b0; #1;
    chk("br_after_ctl", 32'(ctl_a), 32'(C_IDLE));
    chk("br_fcnt", 32'(if_a.FLUSH_CNT), 1);
    chk("br_scnt", 32'(if_a.STALL_CNT), 3);
    tick();

    // A: memory freeze masks stall and branch, then release re-evaluates.
    if_a.MEM_REQ = 1'b1; if_a.MEM_READY = 1'b0; if_a.STALL = 1'b1; #1;
    chk("frz_a0_ctl", 32'(ctl_a), 32'(C_FREEZE));
    tick();
    if_a.STALL = 1'b0; if_a.BRANCH_TAKEN = 1'b1; #1;
    chk("frz_a1_ctl", 32'(ctl_a), 32'(C_FREEZE));
    tick();
    if_a.MEM_READY = 1'b1; if_a.BRANCH_TAKEN = 1'b0; if_a.STALL = 1'b1; #1;
    chk("frz_a_rel_ctl", 32'(ctl_a), 32'(C_STALL));
    tick();
    if_a.MEM_REQ = 1'b0; if_a.MEM_READY = 1'b0; if_a.STALL = 1'b0; #1;
    chk("frz_a_done_ctl", 32'(ctl_a), 32'(C_IDLE));
    chk("frz_a_scnt", 32'(if_a.STALL_CNT), 4);
    chk("frz_a_fcnt", 32'(if_a.FLUSH_CNT), 1);
    chk("frz_a_tmo", 32'(if_a.TIMEOUT), 0);
    tick();

    // B: three-cycle flush, stall ignored in flush cycle 2.
    if_b.BRANCH_TAKEN = 1'b1; #1;
    chk("fl3_c1", 32'(ctl_b), 32'(C_FLUSH));
    tick();
    if_b.BRANCH_TAKEN = 1'b0; if_b.STALL = 1'b1; #1;
    chk("fl3_c2", 32'(ctl_b), 32'(C_FLUSH));
    tick();
    if_b.STALL = 1'b0; #1;
    chk("fl3_c3", 32'(ctl_b), 32'(C_FLUSH));
    tick(); #1;
    chk("fl3_done", 32'(ctl_b), 32'(C_IDLE));
    chk("fl3_fcnt", 32'(if_b.FLUSH_CNT), 1);
    chk("fl3_scnt", 32'(if_b.STALL_CNT), 0);
    tick();

    // B: freeze for 4 cycles starting at flush cycle 2; WCNT reaches 4.
    if_b.BRANCH_TAKEN = 1'b1; #1;
    chk("ff_c1", 32'(ctl_b), 32'(C_FLUSH));
    tick();
    if_b.BRANCH_TAKEN = 1'b0; if_b.MEM_REQ = 1'b1; if_b.MEM_READY = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("ff_frozen", 32'(ctl_b), 32'(C_FREEZE));
      chk("ff_tmo_pre", 32'(if_b.TIMEOUT), 0);
      tick(); #1;
    end
    if_b.MEM_REQ = 1'b0; #1;
    chk("ff_tmo_set", 32'(if_b.TIMEOUT), 1);
    chk("ff_rem1", 32'(ctl_b), 32'(C_FLUSH));
    tick(); #1;
    chk("ff_rem2", 32'(ctl_b), 32'(C_FLUSH));
    tick(); #1;
    chk("ff_run", 32'(ctl_b), 32'(C_IDLE));
    chk("ff_fcnt", 32'(if_b.FLUSH_CNT), 2);
    tick();

    // B: longer freeze after timeout; flag stays sticky after release.
    if_b.MEM_REQ = 1'b1; if_b.MEM_READY = 1'b0;
    repeat (6) tick();
    if_b.MEM_READY = 1'b1; #1;
    chk("tmo_rel_ctl", 32'(ctl_b), 32'(C_IDLE));
    tick();
    if_b.MEM_REQ = 1'b0; if_b.MEM_READY = 1'b0; #1;
    chk("tmo_sticky", 32'(if_b.TIMEOUT), 1);
    tick();

    // B: five stall pulses saturate the 2-bit stall counter at 3.
    for (int i = 0; i < 5; i++) begin
      if_b.STALL = 1'b1; #1;
      chk("sat_stall_ctl", 32'(ctl_b), 32'(C_STALL));
      tick();
      if_b.STALL = 1'b0; #1;
      chk("sat_scnt", 32'(if_b.STALL_CNT), (i + 1 > 3) ? 3 : i + 1);
      tick();
    end

    // B: two more redirects saturate the flush counter at 3.
    for (int i = 0; i < 2; i++) begin
      if_b.BRANCH_TAKEN = 1'b1;
      tick();
      if_b.BRANCH_TAKEN = 1'b0;
      repeat (2) tick();
      #1;
      chk("sat_fcnt", 32'(if_b.FLUSH_CNT), 3);
      chk("sat_fl_done", 32'(ctl_b), 32'(C_IDLE));
      tick();
    end

    // B: reset in the middle of a flush abandons it.
    if_b.BRANCH_TAKEN = 1'b1;
    tick();
    if_b.BRANCH_TAKEN = 1'b0; RESET_N = 1'b0; #1;
    chk("rst_mid_ctl_b", 32'(ctl_b), 32'(C_RESET));
    chk("rst_mid_ctl_a", 32'(ctl_a), 32'(C_RESET));
    tick();
    RESET_N = 1'b1; #1;
    chk("rst_mid_run", 32'(ctl_b), 32'(C_IDLE));
    chk("rst_mid_scnt", 32'(if_b.STALL_CNT), 0);
    chk("rst_mid_fcnt", 32'(if_b.FLUSH_CNT), 0);
    chk("rst_mid_tmo", 32'(if_b.TIMEOUT), 0);
    tick(); #1;
    chk("rst_mid_run2", 32'(ctl_b), 32'(C_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Consumer of the load-use STALL request and the EX-stage branch/jump redirect; drives the per-stage enable, flush and bubble controls of the 5-stage RV32I pipeline.
- Arbitrates three hazard sources with fixed priority: data-memory wait > control-flow flush > load-use stall.
- Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- FLUSH_CYCLES, 1: cycles of IF/ID squash per redirect, range 1..15.
- WAIT_MAX, 64: consecutive memory-wait cycles before TIMEOUT sets, range ≥2.
- CNT_W, 16: width of STALL_CNT and FLUSH_CNT.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  synchronous active-low reset.
- STALL  in  1  load-use hazard request from the ID-stage detector.
- BRANCH_TAKEN  in  1  EX-stage redirect (taken branch, JAL or JALR).
- MEM_REQ  in  1  MEM stage holds a load or store this cycle.
- MEM_READY  in  1  data memory completes the access this cycle.
- PC_EN  out  1  PC register load enable.
- IFID_EN  out  1  IF/ID register enable.
- IFID_FLUSH  out  1  IF/ID register loads a NOP.
- IDEX_EN  out  1  ID/EX register enable.
- IDEX_FLUSH  out  1  ID/EX register loads a bubble.
- EXMEM_EN  out  1  EX/MEM register enable.
- MEMWB_BUBBLE  out  1  MEM/WB register loads a bubble.
- TIMEOUT  out  1  sticky memory-wait timeout flag.
- STALL_CNT  out  CNT_W  load-use bubble count.
- FLUSH_CNT  out  CNT_W  redirect event count.

Behaviour:
- Control outputs are combinational from the state registers and the current inputs, so a hazard acts in the cycle it is signalled. Counters, TIMEOUT and state change on the CLK rising edge.
- States are RUN, FLUSH and WAIT. Supporting registers:
  - RET_STATE (RUN or FLUSH) records where WAIT returns to.
  - FCNT (4 bits) holds the remaining flush cycles.
  - WCNT (log2(WAIT_MAX)+1 bits) counts consecutive wait cycles.
- While RESET_N=0:
  - PC_EN, IFID_EN, IDEX_EN and EXMEM_EN are 0.
  - IFID_FLUSH, IDEX_FLUSH and MEMWB_BUBBLE are 1.
  - On the next edge: state=RUN, FCNT=0, WCNT=0, TIMEOUT=0, both counters=0.
  - Reset during WAIT or FLUSH abandons the operation; there is no deferred action.
- Default (no hazard): all enables 1, all flush and bubble outputs 0.
- Memory freeze condition, evaluated in any state: MEM_REQ=1 and MEM_READY=0.
  - PC_EN, IFID_EN, IDEX_EN and EXMEM_EN are 0, MEMWB_BUBBLE=1, IFID_FLUSH=0, IDEX_FLUSH=0.
  - STALL and BRANCH_TAKEN are ignored that cycle; the requesting instructions stay in place and are re-evaluated on release.
  - Entering from RUN or FLUSH: RET_STATE=current state, WCNT=1, next state=WAIT.
  - In WAIT: WCNT increments and saturates at WAIT_MAX. TIMEOUT sets on the edge where WCNT becomes WAIT_MAX and stays set until reset; the block stays in WAIT.
- WAIT with MEM_READY=1 or MEM_REQ=0 (release): WCNT=0; the outputs for that cycle follow the RET_STATE rules, and the next state follows those rules.
- RUN and BRANCH_TAKEN=1 (no freeze):
  - PC_EN=1, IFID_FLUSH=1, IDEX_FLUSH=1; other enables 1.
  - STALL is ignored, since the stalled instruction is on the wrong path.
  - FLUSH_CNT increments, saturating.
  - If FLUSH_CYCLES>1: FCNT=FLUSH_CYCLES-1 and next state=FLUSH.
- RUN and STALL=1 (no freeze, no branch):
  - PC_EN=0, IFID_EN=0, IDEX_FLUSH=1; EXMEM_EN=1, IDEX_EN=1.
  - STALL_CNT increments, saturating.
  - A STALL held for N cycles inserts N bubbles.
- FLUSH (no freeze):
  - PC_EN=1, IFID_FLUSH=1, IDEX_FLUSH=1. STALL is ignored.
  - FCNT decrements; next state=RUN when FCNT reaches 0.
  - A new BRANCH_TAKEN reloads FCNT=FLUSH_CYCLES-1 and increments FLUSH_CNT.
- Counters saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Reset: hold RESET_N=0 for 3 cycles, then release with no hazards → during reset PC_EN=0, IFID_FLUSH=1, MEMWB_BUBBLE=1; after release all enables=1, both counters=0, TIMEOUT=0.
- Load-use: STALL=1 for 1 cycle → that cycle PC_EN=0, IFID_EN=0, IDEX_FLUSH=1, EXMEM_EN=1; next cycle all enables=1; STALL_CNT=1.
- Branch beats stall: BRANCH_TAKEN=1 and STALL=1 in the same cycle → IFID_FLUSH=1, IDEX_FLUSH=1, PC_EN=1; FLUSH_CNT=1, STALL_CNT=0.
- Multi-cycle flush with FLUSH_CYCLES=3: one BRANCH_TAKEN pulse → IFID_FLUSH=1 for exactly 3 cycles; STALL=1 during cycle 2 is ignored; FLUSH_CNT=1.
- Memory freeze during flush (FLUSH_CYCLES=3): MEM_REQ=1, MEM_READY=0 for 4 cycles starting at flush cycle 2 → 4 frozen cycles with MEMWB_BUBBLE=1, then 2 remaining flush cycles, then RUN.
- Timeout and saturation with WAIT_MAX=4, CNT_W=2: MEM_READY=0 and MEM_REQ=1 for 6 cycles → TIMEOUT=1 from the edge where WCNT reaches 4 and held after release; STALL pulsed 5 times → STALL_CNT=3.
